uart_rx: RTL and testbench

8N1 UART receiver, the receive-side counterpart of the block's transmitter in the UART subsystem. It oversamples the asynchronous RXD line with the system clock and detects the start-bit falling edge. Each bit is sampled at mid-period. Each correctly framed byte is presented on Data with a one-cycle Data_valid strobe; a framing error is flagged with a one-cycle Frame_err strobe.

---
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized RXD, start-edge detect, mid-bit sampling.
// Emits each good byte with a one-cycle Data_valid, or a one-cycle Frame_err on a low stop bit.
module uart_rx #(
   parameter logic [31:0] FREQ_CLK = 32'd100000000,
   parameter logic [31:0] RX_SPEED = 32'd115200
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       RXD,
   output logic [7:0] Data,
   output logic       Data_valid,
   output logic       Frame_err,
   output logic       Busy
);

   localparam logic [31:0] PULSE_END_OF_COUNT = FREQ_CLK / RX_SPEED;
   localparam logic [31:0] HALF_COUNT         = PULSE_END_OF_COUNT / 32'd2;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] START_BIT = 2'd1;
   localparam logic [1:0] RECV_DATA = 2'd2;
   localparam logic [1:0] STOP_BIT  = 2'd3;

   logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= RXD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 32'd0;
            if (rxd_prev_q && !rxd_sync_q) state_d = START_BIT;
         end
         START_BIT: begin
            if (cnt_q == HALF_COUNT) begin
               cnt_d   = 32'd0;
               bit_d   = 32'd0;
               // A start bit that is high again by mid-bit was a glitch.
               state_d = rxd_sync_q ? IDLE : RECV_DATA;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         RECV_DATA: begin
            if (cnt_q == PULSE_END_OF_COUNT) begin
               cnt_d   = 32'd0;
               shift_d = {rxd_sync_q, shift_q[7:1]};
               if (bit_q == 32'd7) state_d = STOP_BIT;
               else                bit_d   = bit_q + 32'd1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            if (cnt_q == PULSE_END_OF_COUNT) begin
               cnt_d   = 32'd0;
               state_d = IDLE;
               if (rxd_sync_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 32'd0;
         bit_q   <= 32'd0;
         shift_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign Data       = data_q;
   assign Data_valid = valid_q;
   assign Frame_err  = ferr_q;
   assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (17-clock and 65-clock bits), table vectors,
// hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd_a = 1'b1, rxd_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

   int checks = 0, failures = 0, mutex_err = 0;
   int evq_a[$], evq_b[$];
   logic [7:0] last_a = 8'h00, last_b = 8'h00;

   always #5 clk = ~clk;

   uart_rx #(.FREQ_CLK(32'd16), .RX_SPEED(32'd1)) u_a (
      .Clk(clk), .Rst_n(rst_n), .RXD(rxd_a), .Data(data_a),
      .Data_valid(valid_a), .Frame_err(ferr_a), .Busy(busy_a));

   uart_rx #(.FREQ_CLK(32'd64), .RX_SPEED(32'd1)) u_b (
      .Clk(clk), .Rst_n(rst_n), .RXD(rxd_b), .Data(data_b),
      .Data_valid(valid_b), .Frame_err(ferr_b), .Busy(busy_b));

   // Strobe monitor: a good byte is 256+data, a framing error is 512.
   always @(negedge clk) begin
      if (valid_a) evq_a.push_back(256 + int'(data_a));
      if (ferr_a)  evq_a.push_back(512);
      if (valid_b) evq_b.push_back(256 + int'(data_b));
      if (ferr_b)  evq_b.push_back(512);
      if ((valid_a && ferr_a) || (valid_b && ferr_b)) mutex_err++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic hold(input int which, input logic v, input int n);
      if (which == 0) rxd_a = v; else rxd_b = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int which, input logic [7:0] d, input logic stop,
                       input int bclk, input int gap);
      if (gap > 0) hold(which, 1'b1, gap);
      hold(which, 1'b0, bclk);
      for (int i = 0; i < 8; i++) hold(which, d[i], bclk);
      hold(which, stop, bclk);
   endtask

   // One frame must yield exactly one strobe; Data must track the last good byte.
   task automatic check_frame(input string nm, input int which, input logic ev,
                              input logic [7:0] exp_data);
      int n; logic [31:0] e; logic [7:0] dq; logic bz;
      if (which == 0) begin
         n = evq_a.size(); e = (n > 0) ? evq_a[0] : 32'hffffffff; evq_a.delete();
         dq = data_a; bz = busy_a;
      end else begin
         n = evq_b.size(); e = (n > 0) ? evq_b[0] : 32'hffffffff; evq_b.delete();
         dq = data_b; bz = busy_b;
      end
      chk({nm, ".n_strobes"}, n, 1);
      chk({nm, ".strobe"}, e, ev ? 256 + int'(exp_data) : 512);
      chk({nm, ".data"}, dq, exp_data);
      chk({nm, ".busy_after"}, bz, 1'b0);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      int         gap;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int bh, gap, bclk;
      logic [7:0] rd, c3;
      logic rs, prev_bad;

      tbl[0] = '{8'hA5, 1'b1, 4, 1'b1, 8'hA5};
      tbl[1] = '{8'h00, 1'b1, 4, 1'b1, 8'h00};
      tbl[2] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
      tbl[3] = '{8'h11, 1'b1, 4, 1'b1, 8'h11};
      tbl[4] = '{8'h3C, 1'b0, 4, 1'b0, 8'h11};

      repeat (3) @(negedge clk);
      chk("rst.data_a", data_a, 8'h00);
      chk("rst.valid_a", valid_a, 1'b0);
      chk("rst.ferr_a", ferr_a, 1'b0);
      chk("rst.busy_a", busy_a, 1'b0);
      chk("rst.busy_b", busy_b, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         send(0, tbl[i].d, tbl[i].stop, 17, tbl[i].gap);
         check_frame($sformatf("tbl%0d", i), 0, tbl[i].exp_valid, tbl[i].exp_data);
         last_a = tbl[i].exp_data;
      end

      // Line left low after the framing error: must not retrigger.
      bh = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy_a) bh++;
      end
      chk("break.busy_cycles", bh, 0);
      chk("break.no_strobe", evq_a.size(), 0);
      send(0, 8'h77, 1'b1, 17, 5);
      check_frame("after_break", 0, 1'b1, 8'h77);
      last_a = 8'h77;

      // Short low glitch: start bit rejected at mid-bit.
      hold(0, 1'b0, 4);
      chk("glitch.busy_high", busy_a, 1'b1);
      hold(0, 1'b1, 20);
      chk("glitch.busy_low", busy_a, 1'b0);
      chk("glitch.no_strobe", evq_a.size(), 0);
      chk("glitch.data", data_a, last_a);

      // Asynchronous reset after the third data bit of 0xC3.
      c3 = 8'hC3;
      hold(0, 1'b0, 17);
      for (int i = 0; i < 3; i++) hold(0, c3[i], 17);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.data", data_a, 8'h00);
      chk("midrst.valid", valid_a, 1'b0);
      chk("midrst.ferr", ferr_a, 1'b0);
      chk("midrst.busy", busy_a, 1'b0);
      rxd_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_a = 8'h00; last_b = 8'h00;
      repeat (2) @(negedge clk);
      chk("midrst.no_strobe", evq_a.size(), 0);
      send(0, 8'h5A, 1'b1, 17, 4);
      check_frame("post_rst", 0, 1'b1, 8'h5A);
      last_a = 8'h5A;

      // Baud tolerance on the 65-clock instance.
      send(1, 8'h81, 1'b1, 63, 4);
      check_frame("fast63", 1, 1'b1, 8'h81);
      send(1, 8'h81, 1'b1, 67, 4);
      check_frame("slow67", 1, 1'b1, 8'h81);
      last_b = 8'h81;

      prev_bad = 1'b0;
      for (int i = 0; i < 24; i++) begin
         rd  = 8'($urandom);
         rs  = ($urandom_range(0, 3) != 0);
         gap = prev_bad ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 10));
         send(0, rd, rs, 17, gap);
         if (rs) last_a = rd;
         check_frame($sformatf("randA%0d", i), 0, rs, last_a);
         prev_bad = !rs;
      end

      prev_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd   = 8'($urandom);
         rs   = ($urandom_range(0, 3) != 0);
         bclk = int'($urandom_range(63, 67));
         gap  = prev_bad ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 10));
         send(1, rd, rs, bclk, gap);
         if (rs) last_b = rd;
         check_frame($sformatf("randB%0d", i), 1, rs, last_b);
         prev_bad = !rs;
      end

      hold(0, 1'b1, 5);
      chk("mutex", mutex_err, 0);
      chk("final.no_strobe_a", evq_a.size(), 0);
      chk("final.no_strobe_b", evq_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
